// File: rtl/risc_constants.sv
`default_nettype none
// ============================================================================
//  Module : risc_constants (package)
//  Brief  : Shared opcode, ALU-function and PC-select encodings plus the
//           datapath control-vector type used by the sequencing controller
//           and its single-cycle decoder.
//  Ports  : none (package)
//  Rev    : 1.0  initial release with PUSHA/POPA multi-word opcodes
// ============================================================================
package risc_constants;

   // Opcodes
   localparam logic [5:0] c_OP_PUSHA = 6'h14;
   localparam logic [5:0] c_OP_POPA  = 6'h15;
   localparam logic [5:0] c_OP_LD    = 6'h18;
   localparam logic [5:0] c_OP_ST    = 6'h19;
   localparam logic [5:0] c_OP_JMP   = 6'h1B;
   localparam logic [5:0] c_OP_BEQ   = 6'h1C;
   localparam logic [5:0] c_OP_BNE   = 6'h1D;
   localparam logic [5:0] c_OP_LDR   = 6'h1F;

   // ALU function codes
   localparam logic [5:0] c_ALU_ADD   = 6'b000000;
   localparam logic [5:0] c_ALU_SUB   = 6'b000001;
   localparam logic [5:0] c_ALU_MUL   = 6'b000010;
   localparam logic [5:0] c_ALU_DIV   = 6'b000011;
   localparam logic [5:0] c_ALU_CMPEQ = 6'b110011;
   localparam logic [5:0] c_ALU_CMPLT = 6'b110101;
   localparam logic [5:0] c_ALU_CMPLE = 6'b110111;
   localparam logic [5:0] c_ALU_AND   = 6'b011000;
   localparam logic [5:0] c_ALU_OR    = 6'b011110;
   localparam logic [5:0] c_ALU_XOR   = 6'b010110;
   localparam logic [5:0] c_ALU_XNOR  = 6'b011001;
   localparam logic [5:0] c_ALU_SHL   = 6'b100000;
   localparam logic [5:0] c_ALU_SHR   = 6'b100001;
   localparam logic [5:0] c_ALU_SRA   = 6'b100011;
   localparam logic [5:0] c_ALU_A     = 6'b011010;

   // PC source select
   localparam logic [2:0] c_PC_INC   = 3'd0;
   localparam logic [2:0] c_PC_BR    = 3'd1;
   localparam logic [2:0] c_PC_JMP   = 3'd2;
   localparam logic [2:0] c_PC_ILLOP = 3'd3;
   localparam logic [2:0] c_PC_IRQ   = 3'd4;

   // Register-file write data select
   localparam logic [1:0] c_WD_PC  = 2'd0;
   localparam logic [1:0] c_WD_ALU = 2'd1;
   localparam logic [1:0] c_WD_MEM = 2'd2;

   typedef struct packed {
      logic [5:0] alufn;
      logic       asel;
      logic       bsel;
      logic       moe;
      logic       mwr;
      logic [2:0] pcsel;
      logic       ra2sel;
      logic       wasel;
      logic [1:0] wdsel;
      logic       werf;
   } ctl_t;

   // Returns {valid, alufn} for the low nibble of an ALU/ALUC opcode.
   function automatic logic [6:0] alu_lookup(input logic [3:0] i_f);
      case (i_f)
         4'h0:    return {1'b1, c_ALU_ADD};
         4'h1:    return {1'b1, c_ALU_SUB};
         4'h2:    return {1'b1, c_ALU_MUL};
         4'h3:    return {1'b1, c_ALU_DIV};
         4'h4:    return {1'b1, c_ALU_CMPEQ};
         4'h5:    return {1'b1, c_ALU_CMPLT};
         4'h6:    return {1'b1, c_ALU_CMPLE};
         4'h8:    return {1'b1, c_ALU_AND};
         4'h9:    return {1'b1, c_ALU_OR};
         4'hA:    return {1'b1, c_ALU_XOR};
         4'hB:    return {1'b1, c_ALU_XNOR};
         4'hC:    return {1'b1, c_ALU_SHL};
         4'hD:    return {1'b1, c_ALU_SHR};
         4'hE:    return {1'b1, c_ALU_SRA};
         default: return 7'd0;
      endcase
   endfunction

   // Trap-style vector (ILLOP / IRQ): save PC into XP, redirect PC.
   function automatic ctl_t trap_ctl(input logic [2:0] i_pcsel);
      ctl_t v_c;
      v_c       = '0;
      v_c.pcsel = i_pcsel;
      v_c.wasel = 1'b1;
      v_c.werf  = 1'b1;
      return v_c;
   endfunction

   // One word of a PUSHA (store) or POPA (load) transfer; address is Ra+mofs.
   function automatic ctl_t multi_step_ctl(input logic i_is_push);
      ctl_t v_c;
      v_c       = '0;
      v_c.alufn = c_ALU_ADD;
      v_c.bsel  = 1'b1;
      if (i_is_push) begin
         v_c.mwr    = 1'b1;
         v_c.ra2sel = 1'b1;
      end else begin
         v_c.moe   = 1'b1;
         v_c.wdsel = c_WD_MEM;
         v_c.werf  = 1'b1;
      end
      return v_c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module : seq_ctl_if (interface)
//  Brief  : Instruction-in / datapath-control-out bundle of seq_ctl.
//  Ports  : op, z, irq           instruction side -> controller
//           alufn..wdsel, stall,
//           mreg, mofs, busy     controller -> datapath
//  Rev    : 1.0  initial release
// ============================================================================
interface seq_ctl_if #(
   parameter int CNT_W = 5
);
   logic [5:0]       op;
   logic             z;
   logic             irq;
   logic [5:0]       alufn;
   logic             asel;
   logic             bsel;
   logic             moe;
   logic             mwr;
   logic             ra2sel;
   logic             wasel;
   logic             werf;
   logic [2:0]       pcsel;
   logic [1:0]       wdsel;
   logic             stall;
   logic [CNT_W-1:0] mreg;
   logic [CNT_W+2:0] mofs;
   logic             busy;

   modport master (
      output op, z, irq,
      input  alufn, asel, bsel, moe, mwr, ra2sel, wasel, werf, pcsel, wdsel,
             stall, mreg, mofs, busy
   );

   modport slave (
      input  op, z, irq,
      output alufn, asel, bsel, moe, mwr, ra2sel, wasel, werf, pcsel, wdsel,
             stall, mreg, mofs, busy
   );
endinterface
`default_nettype wire

// File: rtl/ctl_decode.sv
`default_nettype none
// ============================================================================
//  Module : ctl_decode
//  Brief  : Combinational control table for single-cycle instructions.
//           Anything not recognised here yields the ILLOP trap vector.
//  Ports  : i_op  [5:0] opcode
//           i_z         Ra==0 flag for BEQ/BNE
//           o_ctl       datapath control vector
//  Rev    : 1.0  initial release
// ============================================================================
module ctl_decode
   import risc_constants::*;
(
   input  logic [5:0] i_op,
   input  logic       i_z,
   output ctl_t       o_ctl
);

   logic [6:0] w_alu;

   assign w_alu = alu_lookup(i_op[3:0]);

   always_comb begin
      o_ctl = trap_ctl(c_PC_ILLOP);
      case (i_op)
         c_OP_LD: begin
            o_ctl       = '0;
            o_ctl.alufn = c_ALU_ADD;
            o_ctl.bsel  = 1'b1;
            o_ctl.moe   = 1'b1;
            o_ctl.wdsel = c_WD_MEM;
            o_ctl.werf  = 1'b1;
         end
         c_OP_ST: begin
            o_ctl        = '0;
            o_ctl.alufn  = c_ALU_ADD;
            o_ctl.bsel   = 1'b1;
            o_ctl.mwr    = 1'b1;
            o_ctl.ra2sel = 1'b1;
         end
         c_OP_JMP: begin
            o_ctl       = '0;
            o_ctl.pcsel = c_PC_JMP;
            o_ctl.wdsel = c_WD_PC;
            o_ctl.werf  = 1'b1;
         end
         c_OP_BEQ: begin
            o_ctl       = '0;
            o_ctl.pcsel = i_z ? c_PC_BR : c_PC_INC;
            o_ctl.werf  = 1'b1;
         end
         c_OP_BNE: begin
            o_ctl       = '0;
            o_ctl.pcsel = i_z ? c_PC_INC : c_PC_BR;
            o_ctl.werf  = 1'b1;
         end
         c_OP_LDR: begin
            o_ctl       = '0;
            o_ctl.alufn = c_ALU_A;
            o_ctl.asel  = 1'b1;
            o_ctl.moe   = 1'b1;
            o_ctl.wdsel = c_WD_MEM;
            o_ctl.werf  = 1'b1;
         end
         default: begin
            // 10xxxx = ALU (register B), 11xxxx = ALUC (literal B)
            if (i_op[5] && w_alu[6]) begin
               o_ctl       = '0;
               o_ctl.alufn = w_alu[5:0];
               o_ctl.bsel  = i_op[4];
               o_ctl.wdsel = c_WD_ALU;
               o_ctl.werf  = 1'b1;
            end
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seq_ctl.sv
`default_nettype none
// ============================================================================
//  Module : seq_ctl
//  Brief  : Control unit with a two-state sequencer for the multi-word
//           PUSHA/POPA instructions, deferred interrupts and ILLOP trap.
//  Ports  : clk          rising-edge clock
//           reset_n      asynchronous active-low reset
//           bus (slave)  op/z/irq in; datapath controls, stall, mreg,
//                        mofs, busy out
//  Rev    : 1.0  initial release
// ============================================================================
module seq_ctl
   import risc_constants::*;
#(
   parameter int NREG       = 31,
   parameter int CNT_W      = 5,
   parameter int WORD_BYTES = 4
) (
   input  logic      clk,
   input  logic      reset_n,
   seq_ctl_if.slave  bus
);

   localparam logic [0:0]       c_S_IDLE  = 1'b0;
   localparam logic [0:0]       c_S_MULTI = 1'b1;
   localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(NREG - 1);
   localparam logic [CNT_W+2:0] c_STRIDE  = (CNT_W+3)'(WORD_BYTES);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_irq_pend;
   logic [5:0]       r_op;

   ctl_t             w_dec;
   ctl_t             w_ctl;
   logic             w_stall;
   logic [CNT_W-1:0] w_mreg;
   logic [CNT_W+2:0] w_mofs;
   logic             w_in_multi;
   logic             w_irq_req;
   logic             w_start;
   logic [CNT_W-1:0] w_step;
   logic             w_last;

   ctl_decode u_decode (
      .i_op  (bus.op),
      .i_z   (bus.z),
      .o_ctl (w_dec)
   );

   assign w_in_multi = (r_state == c_S_MULTI);
   assign w_irq_req  = bus.irq | r_irq_pend;
   assign w_start    = (bus.op == c_OP_PUSHA) || (bus.op == c_OP_POPA);
   // Step 0 is always issued from IDLE, so the counter only matters in MULTI.
   assign w_step     = w_in_multi ? r_cnt : '0;
   assign w_last     = (w_step == c_LAST);

   always_comb begin
      w_ctl   = '0;
      w_stall = 1'b0;
      w_mreg  = '0;
      w_mofs  = '0;
      // Outputs are forced low combinationally for the whole reset window.
      if (reset_n) begin
         if (w_in_multi) begin
            w_ctl   = multi_step_ctl(r_op == c_OP_PUSHA);
            w_stall = !w_last;
            w_mreg  = w_step;
            w_mofs  = (CNT_W+3)'(w_step) * c_STRIDE;
         end else if (w_irq_req) begin
            w_ctl = trap_ctl(c_PC_IRQ);
         end else if (w_start) begin
            w_ctl   = multi_step_ctl(bus.op == c_OP_PUSHA);
            w_stall = !w_last;
         end else begin
            w_ctl = w_dec;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= c_S_IDLE;
         r_cnt      <= '0;
         r_irq_pend <= 1'b0;
         r_op       <= '0;
      end else if (w_in_multi) begin
         r_irq_pend <= r_irq_pend | bus.irq;
         if (w_last) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end else if (w_irq_req) begin
         r_irq_pend <= 1'b0;
      end else if (w_start) begin
         // Opcode is captured here so later op changes cannot alter the transfer.
         r_op <= bus.op;
         if (!w_last) begin
            r_state <= c_S_MULTI;
            r_cnt   <= CNT_W'(1);
         end
      end
   end

   assign bus.alufn  = w_ctl.alufn;
   assign bus.asel   = w_ctl.asel;
   assign bus.bsel   = w_ctl.bsel;
   assign bus.moe    = w_ctl.moe;
   assign bus.mwr    = w_ctl.mwr;
   assign bus.pcsel  = w_ctl.pcsel;
   assign bus.ra2sel = w_ctl.ra2sel;
   assign bus.wasel  = w_ctl.wasel;
   assign bus.wdsel  = w_ctl.wdsel;
   assign bus.werf   = w_ctl.werf;
   assign bus.stall  = w_stall;
   assign bus.mreg   = w_mreg;
   assign bus.mofs   = w_mofs;
   assign bus.busy   = reset_n & w_in_multi;

endmodule
`default_nettype wire

// File: doc/seq_ctl.md
SEQ_CTL -- requirements
Module: seq_ctl

Interface
REQ-001 Parameter NREG, default 31: number of registers moved by one PUSHA/POPA, legal range 1..31.
REQ-002 Parameter CNT_W, default 5: step counter width; must satisfy 2**CNT_W >= NREG.
REQ-003 Parameter WORD_BYTES, default 4: byte stride between consecutive words of a multi-word transfer.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 op  in  6  opcode of the current instruction.
REQ-007 z  in  1  Ra==0 flag, used by BEQ/BNE.
REQ-008 irq  in  1  level interrupt request.
REQ-009 alufn  out  6; asel, bsel, moe, mwr, ra2sel, wasel, werf  out  1 each; pcsel  out  3; wdsel  out  2: datapath controls, same field meanings as the existing decoder.
REQ-010 stall  out  1  hold PC and IR this cycle.
REQ-011 mreg  out  CNT_W  register index for the current multi-word step.
REQ-012 mofs  out  CNT_W+3  byte offset of the current step, added to Ra.
REQ-013 busy  out  1  high while the FSM is in state MULTI.

Function
REQ-014 Single-cycle ops LD, ST, JMP, BEQ, BNE, LDR, ALU and ALUC SHALL produce the same control vectors as the existing decoder, combinationally from op and z; for these ops stall=0, mreg=0, mofs=0.
REQ-015 The FSM SHALL have two states: IDLE (instruction boundary) and MULTI.
REQ-016 In IDLE with op = PUSHA or POPA, the block SHALL issue step 0; if NREG>1 it SHALL assert stall=1 and move to MULTI with cnt=1; if NREG=1 it SHALL assert stall=0 and stay in IDLE.
REQ-017 In MULTI, the block SHALL issue step cnt and increment cnt each cycle; stall=1 except on step NREG-1, where stall=0 and the next state is IDLE with cnt=0.
REQ-018 For a step k, mreg=k and mofs=k*WORD_BYTES, zero-extended.
REQ-019 PUSHA step: alufn=ADD, bsel=1, mwr=1, ra2sel=1, werf=0, moe=0; read port 2 addresses mreg.
REQ-020 POPA step: alufn=ADD, bsel=1, moe=1, wdsel=2, werf=1, mwr=0; write address is mreg.
REQ-021 A PUSHA/POPA therefore occupies exactly NREG cycles.
REQ-022 Any opcode not listed in REQ-014 or REQ-016 is ILLOP, handled in IDLE only: pcsel=3, wasel=1, werf=1, all other controls 0, stall=0.
REQ-023 Interrupts SHALL be taken only in IDLE; the IRQ vector is pcsel=4, wasel=1, werf=1, all other controls 0, stall=0.
REQ-024 An irq asserted while in MULTI SHALL set irq_pend; it SHALL NOT disturb any step.
REQ-025 In IDLE, the interrupt request is irq OR irq_pend; taking it clears irq_pend on that edge.
REQ-026 Priority in IDLE: interrupt > multi-op start > ILLOP/single-cycle decode.
REQ-027 op and z are sampled only in IDLE; changes to op while in MULTI SHALL be ignored, because the opcode is latched at step 0.

Reset
REQ-028 While reset_n=0, all outputs SHALL be 0: pcsel=0, werf=0, mwr=0, stall=0, busy=0, mreg=0, mofs=0.
REQ-029 Reset SHALL force state IDLE, cnt=0, irq_pend=0 and clear the latched opcode, including when asserted mid-MULTI; the aborted transfer is not resumed.
REQ-030 The first edge after reset_n rises SHALL decode normally from IDLE.

Structure
REQ-031 Opcode values (including new PUSHA, POPA), alu_* codes and the pcsel encodings 0/1/2/3/4 SHALL live in the shared risc_constants package.
REQ-032 The combinational single-cycle table SHALL be one sub-module, ctl_decode; the FSM, counter and irq_pend SHALL remain in seq_ctl.

Verification
REQ-033 ADDC with irq=0 -> alufn=ADD, bsel=1, wdsel=1, werf=1, stall=0, busy=0 in the same cycle.
REQ-034 PUSHA, NREG=31, WORD_BYTES=4 -> 31 cycles with mwr=1; mreg runs 0..30; mofs runs 0..120; stall=1 for cycles 0..29 and 0 on cycle 30; busy high for cycles 1..30.
REQ-035 POPA, NREG=1 -> a single cycle with werf=1, moe=1, mreg=0, stall=0; the FSM never enters MULTI.
REQ-036 irq pulsed at step 5 of PUSHA (NREG=31) -> steps 6..30 unchanged; on the next IDLE cycle pcsel=4, wasel=1; irq_pend then clears.
REQ-037 reset_n low at step 10 of POPA -> all outputs 0 immediately; after release an ADD decodes with werf=1 and stall=0.
REQ-038 Undefined opcode 6'h3F in IDLE -> pcsel=3, wasel=1, werf=1, mwr=0, stall=0.
